// File: rtl/glitch_pkg.sv
// glitch_pkg
//   Shared types and defaults for the glitch trigger/pulse path.
//   - state_t    : trigger-delay FSM states (also exported on the debug port)
//   - fire_req_t : fire request payload handed to the pulse generator
//   - DEFAULT_*  : default widths for delay values and pulse width field
package glitch_pkg;

    localparam int DEFAULT_DELAY_W = 32;
    localparam int DEFAULT_WIDTH_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_FIRE    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH_W-1:0] width;
    } fire_req_t;

endpackage

// File: rtl/trig_sync.sv
// trig_sync
//   Brings the asynchronous target trigger into the clock domain and
//   produces a single-cycle, registered edge pulse of the selected polarity.
//   Ports:
//     i_clk, i_rst_n   : clock, asynchronous active-low reset
//     i_trig_in        : raw asynchronous trigger line
//     i_trig_rising    : 1 = rising edge, 0 = falling edge
//     o_trig_edge      : one-cycle pulse, high the cycle after edge
//                        k+SYNC_STAGES (k = first edge sampling the new level)
module trig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trig_in,
    input  logic i_trig_rising,
    output logic o_trig_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;
    logic                   w_sync_out;
    logic                   w_edge;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Polarity is applied combinationally before the edge register, so a
    // change of i_trig_rising with a static line never produces a pulse.
    assign w_edge = i_trig_rising ? (w_sync_out & ~r_prev)
                                  : (~w_sync_out & r_prev);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_trig_in};
            r_prev <= w_sync_out;
            r_edge <= w_edge;
        end
    end

    assign o_trig_edge = r_edge;

endmodule

// File: rtl/glitch_trigger_delay.sv
// glitch_trigger_delay
//   Waits a programmable delay after a synchronised trigger edge, then
//   issues one fire request to the pulse generator. After every accepted
//   shot the delay advances through a start/step/end sweep.
//   Handshake: o_fire_valid rises in FIRE and stays high, with o_fire_width
//   stable, until the cycle in which i_fire_ready is also high; the
//   transfer happens on that clock edge and valid drops on the same edge.
//   Ports:
//     i_clk, i_rst_n                 : clock, asynchronous active-low reset
//     i_trig_in, i_trig_rising       : raw trigger and edge polarity select
//     i_arm, i_abort, i_sweep_clr    : control strobes
//     i_delay_start/step/end         : sweep bounds (cycles)
//     i_glitch_width                 : requested pulse width (0 -> 1)
//     o_fire_valid, o_fire_width,
//     i_fire_ready                   : fire request handshake
//     o_armed, o_busy, o_state       : status / debug state
//     o_cur_delay, o_attempts,
//     o_sweep_done                   : sweep status
module glitch_trigger_delay
    import glitch_pkg::*;
#(
    parameter int DELAY_W     = DEFAULT_DELAY_W,
    parameter int WIDTH_W     = DEFAULT_WIDTH_W,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_trig_in,
    input  logic               i_trig_rising,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic               i_sweep_clr,
    input  logic [DELAY_W-1:0] i_delay_start,
    input  logic [DELAY_W-1:0] i_delay_step,
    input  logic [DELAY_W-1:0] i_delay_end,
    input  logic [WIDTH_W-1:0] i_glitch_width,
    output logic               o_fire_valid,
    output logic [WIDTH_W-1:0] o_fire_width,
    input  logic               i_fire_ready,
    output logic               o_armed,
    output logic               o_busy,
    output logic [DELAY_W-1:0] o_cur_delay,
    output logic [15:0]        o_attempts,
    output logic               o_sweep_done,
    output state_t             o_state
);

    // The delay counter doubles as the holdoff counter; HOLDOFF must fit.
    localparam logic [DELAY_W-1:0] HOLDOFF_CNT = DELAY_W'(HOLDOFF);

    state_t             r_state;
    state_t             w_next_state;
    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] w_cnt_next;
    logic [WIDTH_W-1:0] r_fire_width;
    logic [DELAY_W-1:0] r_cur_delay;
    logic [15:0]        r_attempts;
    logic               r_sweep_done;

    logic               w_trig_edge;
    logic               w_accept;
    logic               w_arm_take;
    logic               w_clr_take;
    logic [DELAY_W:0]   w_sweep_sum;
    logic               w_sweep_wrap;
    logic [WIDTH_W-1:0] w_width_clamped;

    trig_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_trig_in     (i_trig_in),
        .i_trig_rising (i_trig_rising),
        .o_trig_edge   (w_trig_edge)
    );

    assign w_accept   = (r_state == ST_FIRE) && i_fire_ready;
    assign w_arm_take = (r_state == ST_IDLE) && i_arm;
    assign w_clr_take = (r_state == ST_IDLE) && i_sweep_clr;

    // One extra bit so a sum overflowing DELAY_W still compares as "past end".
    assign w_sweep_sum  = {1'b0, r_cur_delay} + {1'b0, i_delay_step};
    assign w_sweep_wrap = w_sweep_sum > {1'b0, i_delay_end};

    assign w_width_clamped = (i_glitch_width == '0) ? WIDTH_W'(1) : i_glitch_width;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_arm) begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Abort takes priority over a coincident trigger edge.
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_trig_edge) begin
                    w_next_state = ST_DELAY;
                    w_cnt_next   = r_cur_delay;
                end
            end
            ST_DELAY: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_FIRE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_FIRE: begin
                // No abort here: a raised request is never withdrawn.
                if (i_fire_ready) begin
                    w_next_state = ST_HOLDOFF;
                    w_cnt_next   = HOLDOFF_CNT;
                end
            end
            ST_HOLDOFF: begin
                if (i_abort || (r_cnt == '0)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fire_width <= '0;
            r_cur_delay  <= '0;
            r_attempts   <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            if (w_arm_take) begin
                r_fire_width <= w_width_clamped;
            end
            if (w_clr_take) begin
                r_cur_delay  <= i_delay_start;
                r_attempts   <= '0;
                r_sweep_done <= 1'b0;
            end else if (w_accept) begin
                r_attempts <= r_attempts + 16'd1;
                if (w_sweep_wrap) begin
                    r_cur_delay  <= i_delay_start;
                    r_sweep_done <= 1'b1;
                end else begin
                    r_cur_delay <= w_sweep_sum[DELAY_W-1:0];
                end
            end
        end
    end

    assign o_fire_valid = (r_state == ST_FIRE);
    assign o_fire_width = r_fire_width;
    assign o_armed      = (r_state == ST_ARMED) || (r_state == ST_DELAY);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_cur_delay  = r_cur_delay;
    assign o_attempts   = r_attempts;
    assign o_sweep_done = r_sweep_done;
    assign o_state      = r_state;

endmodule
